// File: rtl/interrupt_sequencer.sv
// Timer-interrupt entry/exit sequencer: stalls the core, snapshots the return PC,
// vectors to the ISR, then stalls again and hands the saved PC back on return.
module interrupt_sequencer #(
  parameter int                      ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] ISR_PC       = 'h100,
  parameter int                      STALL_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    irq,
  input  logic                    irq_enable,
  input  logic [ADDRESS_BITS-1:0] current_PC,
  input  logic                    handler_return,
  output logic                    interrupt_stall,
  output logic                    interrupt_jump,
  output logic                    interrupt_execute,
  output logic                    interrupt_done,
  output logic [ADDRESS_BITS-1:0] saved_PC,
  output logic [ADDRESS_BITS-1:0] vector_PC,
  output logic                    irq_ack,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE,
    ENTER_STALL,
    JUMP,
    SERVICE,
    EXIT_STALL,
    RETURN
  } state_t;

  localparam logic [7:0] STALL_INIT = 8'(STALL_CYCLES - 1);

  state_t     state;
  logic [7:0] stall_count;
  logic       irq_q;
  logic       pending;
  logic       irq_edge;

  assign irq_edge  = irq & ~irq_q;
  assign vector_PC = ISR_PC;

  // Outputs are assigned alongside the state they belong to, so they are
  // registered and line up exactly with the state they decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      stall_count       <= 8'd0;
      irq_q             <= 1'b0;
      pending           <= 1'b0;
      saved_PC          <= '0;
      interrupt_stall   <= 1'b0;
      interrupt_jump    <= 1'b0;
      interrupt_execute <= 1'b0;
      interrupt_done    <= 1'b0;
      irq_ack           <= 1'b0;
      busy              <= 1'b0;
    end else begin
      irq_q          <= irq;
      // A fresh edge in the ack cycle must survive the clear.
      pending        <= irq_edge | (pending & ~irq_ack);
      interrupt_jump <= 1'b0;
      irq_ack        <= 1'b0;
      interrupt_done <= 1'b0;

      case (state)
        IDLE: begin
          if (pending && irq_enable) begin
            state           <= ENTER_STALL;
            stall_count     <= STALL_INIT;
            interrupt_stall <= 1'b1;
            busy            <= 1'b1;
          end
        end
        ENTER_STALL: begin
          if (stall_count != 8'd0) begin
            stall_count <= stall_count - 8'd1;
          end else begin
            saved_PC          <= current_PC;
            state             <= JUMP;
            interrupt_jump    <= 1'b1;
            irq_ack           <= 1'b1;
            interrupt_execute <= 1'b1;
          end
        end
        JUMP: begin
          state           <= SERVICE;
          interrupt_stall <= 1'b0;
        end
        SERVICE: begin
          if (handler_return) begin
            state           <= EXIT_STALL;
            stall_count     <= STALL_INIT;
            interrupt_stall <= 1'b1;
          end
        end
        EXIT_STALL: begin
          if (stall_count != 8'd0) begin
            stall_count <= stall_count - 8'd1;
          end else begin
            state             <= RETURN;
            interrupt_done    <= 1'b1;
            interrupt_execute <= 1'b0;
          end
        end
        RETURN: begin
          state           <= IDLE;
          interrupt_stall <= 1'b0;
          busy            <= 1'b0;
        end
        default: begin
          state             <= IDLE;
          interrupt_stall   <= 1'b0;
          interrupt_execute <= 1'b0;
          busy              <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Drives a STALL_CYCLES=2 and a STALL_CYCLES=1 instance with shared stimulus and
// compares both every cycle against a phase/offset timeline model.
module tb_interrupt_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        irq, irq_enable, handler_return;
  logic [31:0] current_PC;

  logic        stall2, jump2, exec2, done2, ack2, busy2;
  logic [31:0] saved2, vector2;
  logic        stall1, jump1, exec1, done1, ack1, busy1;
  logic [31:0] saved1, vector1;

  interrupt_sequencer #(.ADDRESS_BITS(32), .ISR_PC(32'h100), .STALL_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .irq(irq), .irq_enable(irq_enable),
    .current_PC(current_PC), .handler_return(handler_return),
    .interrupt_stall(stall2), .interrupt_jump(jump2), .interrupt_execute(exec2),
    .interrupt_done(done2), .saved_PC(saved2), .vector_PC(vector2),
    .irq_ack(ack2), .busy(busy2));

  interrupt_sequencer #(.ADDRESS_BITS(32), .ISR_PC(32'h100), .STALL_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .irq(irq), .irq_enable(irq_enable),
    .current_PC(current_PC), .handler_return(handler_return),
    .interrupt_stall(stall1), .interrupt_jump(jump1), .interrupt_execute(exec1),
    .interrupt_done(done1), .saved_PC(saved1), .vector_PC(vector1),
    .irq_ack(ack1), .busy(busy1));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: mode 0 = idle, 1 = entry timeline from t0, 2 = exit timeline from t0.
  int          m_mode[2];
  int          m_t0[2];
  logic        m_pend[2];
  logic [31:0] m_saved[2];
  logic        m_prev;

  int ack_cnt[2];
  int jcyc[2];
  int dcyc[2];

  function automatic int stall_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // {stall, jump, execute, done, ack, busy}
  function automatic logic [5:0] exp_flags(int i);
    int s = stall_of(i);
    int off = cyc - m_t0[i];
    logic [5:0] f = 6'b0;
    if (m_mode[i] == 1) begin
      f = {off <= s, off == s, off >= s, 1'b0, off == s, 1'b1};
    end else if (m_mode[i] == 2) begin
      f = {1'b1, 1'b0, off < s, off == s, 1'b0, 1'b1};
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i]  = 0;
      m_t0[i]    = 0;
      m_pend[i]  = 1'b0;
      m_saved[i] = 32'h0;
    end
    m_prev = 1'b0;
  endtask

  task automatic model_adv();
    logic edge_now = irq && !m_prev;
    for (int i = 0; i < 2; i++) begin
      int s = stall_of(i);
      int off = cyc - m_t0[i];
      logic ack_now = (m_mode[i] == 1) && (off == s);
      if (m_mode[i] == 0) begin
        if (m_pend[i] && irq_enable) begin
          m_mode[i] = 1;
          m_t0[i]   = cyc + 1;
        end
      end else if (m_mode[i] == 1) begin
        if (off == s - 1) m_saved[i] = current_PC;
        if (off > s && handler_return) begin
          m_mode[i] = 2;
          m_t0[i]   = cyc + 1;
        end
      end else if (off == s) begin
        m_mode[i] = 0;
      end
      m_pend[i] = edge_now | (m_pend[i] & ~ack_now);
    end
    m_prev = irq;
  endtask

  task automatic step();
    @(negedge clock);
    chk("flags_s2", 32'({stall2, jump2, exec2, done2, ack2, busy2}), 32'(exp_flags(0)));
    chk("saved_s2", saved2, m_saved[0]);
    chk("flags_s1", 32'({stall1, jump1, exec1, done1, ack1, busy1}), 32'(exp_flags(1)));
    chk("saved_s1", saved1, m_saved[1]);
    if (ack2) ack_cnt[0]++;
    if (ack1) ack_cnt[1]++;
    if (jump2 && jcyc[0] < 0) jcyc[0] = cyc;
    if (jump1 && jcyc[1] < 0) jcyc[1] = cyc;
    if (done2 && dcyc[0] < 0) dcyc[0] = cyc;
    if (done1 && dcyc[1] < 0) dcyc[1] = cyc;
    model_adv();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_marks();
    jcyc[0] = -1; jcyc[1] = -1; dcyc[0] = -1; dcyc[1] = -1;
  endtask

  task automatic wait_jump(input int i, input int budget);
    for (int k = 0; k < budget && jcyc[i] < 0; k++) step();
  endtask

  task automatic wait_done(input int i, input int budget);
    for (int k = 0; k < budget && dcyc[i] < 0; k++) step();
  endtask

  task automatic pulse_return();
    handler_return = 1'b1;
    step();
    handler_return = 1'b0;
  endtask

  // Asserted between edges: outputs must clear without a clock.
  task automatic do_reset();
    irq = 1'b0;
    handler_return = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_flags_s2", 32'({stall2, jump2, exec2, done2, ack2, busy2}), 32'h0);
    chk("async_saved_s2", saved2, 32'h0);
    chk("async_flags_s1", 32'({stall1, jump1, exec1, done1, ack1, busy1}), 32'h0);
    chk("async_saved_s1", saved1, 32'h0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc++;
  endtask

  initial begin
    int e, k, a2, a1;
    logic [31:0] ret_pc;
    reset = 1'b1; irq = 1'b0; irq_enable = 1'b0; handler_return = 1'b0;
    current_PC = 32'h0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    model_reset();
    clear_marks();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    steps(2);
    chk("vector_PC", vector2, 32'h100);

    // Basic sequence with latency checks on both instances.
    current_PC = 32'h40; irq_enable = 1'b1; irq = 1'b1; e = cyc;
    clear_marks();
    wait_jump(0, 20);
    chk("t1_jump_lat_s2", 32'(jcyc[0] - e), 32'd4);
    chk("t1_jump_lat_s1", 32'(jcyc[1] - e), 32'd3);
    chk("t1_saved", saved2, 32'h40);
    irq = 1'b0;
    while (cyc < e + 10) step();
    pulse_return();
    wait_done(0, 20);
    chk("t1_done_lat_s2", 32'(dcyc[0] - (e + 10)), 32'd3);
    chk("t1_done_lat_s1", 32'(dcyc[1] - (e + 10)), 32'd2);
    steps(3);

    // Masked request stays pending until enabled.
    irq_enable = 1'b0; irq = 1'b1; step(); irq = 1'b0;
    a2 = ack_cnt[0];
    steps(6);
    chk("t2_masked_acks", 32'(ack_cnt[0] - a2), 32'd0);
    irq_enable = 1'b1; k = cyc;
    clear_marks();
    wait_jump(0, 20);
    chk("t2_enable_lat", 32'(jcyc[0] - k), 32'd3);
    steps(2);
    pulse_return();
    steps(6);

    // Nested edge during service is deferred until after return.
    current_PC = 32'h80; irq = 1'b1; step(); irq = 1'b0;
    clear_marks();
    wait_jump(0, 20);
    ret_pc = saved2;
    a2 = ack_cnt[0];
    current_PC = 32'h104;
    steps(2);
    irq = 1'b1; step(); irq = 1'b0;
    steps(5);
    chk("t3_no_nested_jump", 32'(ack_cnt[0] - a2), 32'd0);
    pulse_return();
    current_PC = ret_pc;
    clear_marks();
    wait_jump(0, 20);
    chk("t3_resaved", saved2, ret_pc);
    steps(2);
    pulse_return();
    steps(8);

    // Level irq held high: one ack only; spurious return in idle ignored.
    a2 = ack_cnt[0]; a1 = ack_cnt[1];
    irq = 1'b1;
    steps(100);
    chk("t4_level_acks_s2", 32'(ack_cnt[0] - a2), 32'd1);
    chk("t4_level_acks_s1", 32'(ack_cnt[1] - a1), 32'd1);
    pulse_return();
    irq = 1'b0;
    steps(8);
    pulse_return();
    steps(3);
    chk("t4_spurious_busy", 32'({busy2, busy1}), 32'h0);

    // Reset mid-ENTER_STALL and mid-SERVICE.
    current_PC = 32'h3c; irq = 1'b1; step(); irq = 1'b0; step(); step();
    do_reset();
    a2 = ack_cnt[0];
    steps(10);
    chk("t5_no_jump_after_rst1", 32'(ack_cnt[0] - a2), 32'd0);
    irq = 1'b1; step(); irq = 1'b0;
    steps(8);
    do_reset();
    steps(10);
    chk("t5_no_done_after_rst2", 32'({busy2, busy1}), 32'h0);

    // Edge coincident with the STALL_CYCLES=1 ack keeps pending set.
    irq_enable = 1'b1;
    a2 = ack_cnt[0]; a1 = ack_cnt[1];
    irq = 1'b1; step(); irq = 1'b0; step(); step();
    irq = 1'b1; step(); irq = 1'b0;
    steps(3);
    pulse_return();
    steps(15);
    chk("t6_coincident_acks_s1", 32'(ack_cnt[1] - a1), 32'd2);
    chk("t6_merged_acks_s2", 32'(ack_cnt[0] - a2), 32'd1);
    pulse_return();
    steps(10);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 5) == 0) irq = ~irq;
        irq_enable = ($urandom_range(0, 3) != 0);
        handler_return = ($urandom_range(0, 7) == 0);
        current_PC = $urandom;
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
